i2s_tx: RTL and testbench
=========================

I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 SHALL have parameter SCLK_DIV, default 4, meaning clk cycles per sclk half-period (legal range 2..255).
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port l_data  input  24  signed left sample, two's complement.
REQ-005 SHALL have port r_data  input  24  signed right sample, two's complement.
REQ-006 SHALL have port ena  output  1  sample-rate strobe to upstream generator, one clk wide.
REQ-007 SHALL have port sclk  output  1  I2S bit clock.
REQ-008 SHALL have port lrclk  output  1  I2S word select.
REQ-009 SHALL have port sdata  output  1  I2S serial data, MSB first.

Function
REQ-010 SHALL run div_cnt 0..SCLK_DIV-1, wrapping; sclk toggles on the clk edge where div_cnt wraps, giving sclk = clk/(2*SCLK_DIV).
REQ-011 SHALL define a "fall event" as the clk edge where sclk goes 1->0; sdata, lrclk and bit_cnt change only on fall events.
REQ-012 SHALL run bit_cnt 0..63 (6 bits), incrementing on each fall event, wrapping 63->0.
REQ-013 SHALL form a 64-bit-clock frame: bit_cnt 0..31 = left slot, 32..63 = right slot.
REQ-014 SHALL, on the fall event where bit_cnt wraps 63->0, load l_data and r_data together into internal holding registers; holding registers are unchanged at any other time.
REQ-015 SHALL pulse ena high for exactly one clk cycle, on the fall event where bit_cnt goes 31->32; ena period = 128*SCLK_DIV clk (512 at default).
REQ-016 SHALL drive lrclk = 0 during bit_cnt 0..31 and 1 during bit_cnt 32..63 (I2S format).
REQ-017 SHALL, in I2S format, output slot bit k (k = bit_cnt mod 32) as: k=0 -> 0; k=1..24 -> holding bit (24-k), MSB first; k=25..31 -> 0.
REQ-018 SHALL serialise the right slot from the right holding register identically to REQ-017.
REQ-019 SHALL ignore l_data/r_data changes between loads; a change arriving in the same cycle as a load is captured.
REQ-020 SHALL perform no arithmetic on samples; -8388608 (0x800000) and +8388607 (0x7FFFFF) are transmitted bit-exact.

Reset
REQ-021 SHALL, while reset is high, force div_cnt=0, sclk=0, bit_cnt=63, lrclk=1, sdata=0, ena=0 and both holding registers to 0.
REQ-022 SHALL make the first fall event after reset release occur 2*SCLK_DIV clk cycles after release; it wraps bit_cnt to 0 and loads the holding registers.
REQ-023 SHALL, on reset asserted mid-frame, abort the frame immediately; no partial word resumes after release.

Configuration
REQ-024 SHALL, when macro I2S_LJ_FORMAT_EN is defined, use left-justified format: slot bit k=0..23 -> holding bit (23-k), k=24..31 -> 0, lrclk = 1 for the left slot and 0 for the right slot, and lrclk reset value = 0.
REQ-025 SHALL, when I2S_LJ_FORMAT_EN is undefined, use the I2S format of REQ-016..REQ-018 and REQ-021; all other behaviour is identical in both builds.

Verification
REQ-026 SHALL cover reset/timing: SCLK_DIV=4, release reset -> sclk period 8 clk, first fall at clk 8, ena pulses every 512 clk, first at clk 8+32*8=264.
REQ-027 SHALL cover I2S data: l_data=0xA5C3F1, r_data=0x5A3C0F held -> left slot sdata = 0,A5C3F1 MSB first,0000000; right slot = 0,5A3C0F,0000000; lrclk 0 then 1.
REQ-028 SHALL cover extremes: l_data=0x800000, r_data=0x7FFFFF -> left slot bits 1..24 = 1 then 23 zeros; right = 0 then 23 ones.
REQ-029 SHALL cover mid-frame input change: change l_data from 0x111111 to 0x222222 at bit_cnt=10 -> current frame sends 0x111111, next frame 0x222222.
REQ-030 SHALL cover reset mid-frame: assert reset at bit_cnt=40 for 3 clk -> outputs at REQ-021 values during reset, frame restarts per REQ-022.
REQ-031 SHALL cover I2S_LJ_FORMAT_EN build: l_data=0xA5C3F1 -> left slot bits 0..23 = 0xA5C3F1, lrclk=1 during left slot, reset lrclk=0.

Source files
------------

// File: rtl/i2s_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : i2s_tx
// Purpose  : 24-bit stereo I2S transmitter, 64 sclk per frame, sclk derived
//            from clk by SCLK_DIV. Define I2S_LJ_FORMAT_EN for left-justified.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_tx #(
  parameter int unsigned SCLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] l_data,
  input  logic [23:0] r_data,
  output logic        ena,
  output logic        sclk,
  output logic        lrclk,
  output logic        sdata
);

  localparam logic [7:0] DIV_LAST = 8'(SCLK_DIV - 1);
`ifdef I2S_LJ_FORMAT_EN
  localparam logic LRCLK_RESET = 1'b0;
`else
  localparam logic LRCLK_RESET = 1'b1;
`endif

  logic [7:0]  div_cnt_q, div_cnt_d;
  logic        sclk_q, sclk_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic        lrclk_q, lrclk_d;
  logic        sdata_q, sdata_d;
  logic        ena_q, ena_d;
  logic [23:0] l_hold_q, l_hold_d;
  logic [23:0] r_hold_q, r_hold_d;

  logic        div_wrap;
  logic        fall_evt;
  logic        frame_wrap;
  logic [4:0]  slot_bit;
  logic [23:0] slot_word;
  logic        slot_val;
  logic        next_lrclk;

  always_comb begin
    div_wrap   = (div_cnt_q == DIV_LAST);
    fall_evt   = div_wrap & sclk_q;
    frame_wrap = fall_evt & (bit_cnt_q == 6'd63);

    div_cnt_d = div_wrap ? 8'd0 : div_cnt_q + 8'd1;
    sclk_d    = sclk_q ^ div_wrap;
    bit_cnt_d = fall_evt ? bit_cnt_q + 6'd1 : bit_cnt_q;
    ena_d     = fall_evt & (bit_cnt_q == 6'd31);

    l_hold_d  = frame_wrap ? l_data : l_hold_q;
    r_hold_d  = frame_wrap ? r_data : r_hold_q;

    // Output bit is chosen for the slot position being entered, so a word
    // loaded on this edge is already visible to the serialiser.
    slot_bit  = bit_cnt_d[4:0];
    slot_word = bit_cnt_d[5] ? r_hold_d : l_hold_d;
    slot_val  = 1'b0;
`ifdef I2S_LJ_FORMAT_EN
    if (slot_bit <= 5'd23) begin
      slot_val = slot_word[5'd23 - slot_bit];
    end
    next_lrclk = ~bit_cnt_d[5];
`else
    if ((slot_bit >= 5'd1) && (slot_bit <= 5'd24)) begin
      slot_val = slot_word[5'd24 - slot_bit];
    end
    next_lrclk = bit_cnt_d[5];
`endif

    sdata_d = fall_evt ? slot_val   : sdata_q;
    lrclk_d = fall_evt ? next_lrclk : lrclk_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= 8'd0;
      sclk_q    <= 1'b0;
      bit_cnt_q <= 6'd63;
      lrclk_q   <= LRCLK_RESET;
      sdata_q   <= 1'b0;
      ena_q     <= 1'b0;
      l_hold_q  <= 24'd0;
      r_hold_q  <= 24'd0;
    end else begin
      div_cnt_q <= div_cnt_d;
      sclk_q    <= sclk_d;
      bit_cnt_q <= bit_cnt_d;
      lrclk_q   <= lrclk_d;
      sdata_q   <= sdata_d;
      ena_q     <= ena_d;
      l_hold_q  <= l_hold_d;
      r_hold_q  <= r_hold_d;
    end
  end

  assign ena   = ena_q;
  assign sclk  = sclk_q;
  assign lrclk = lrclk_q;
  assign sdata = sdata_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_i2s_tx
// Purpose  : Directed self-checking bench for i2s_tx at SCLK_DIV = 4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_tx;

  logic        clk;
  logic        reset;
  logic [23:0] l_data;
  logic [23:0] r_data;
  logic        ena;
  logic        sclk;
  logic        lrclk;
  logic        sdata;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef I2S_LJ_FORMAT_EN
  localparam logic LR_RST = 1'b0;
`else
  localparam logic LR_RST = 1'b1;
`endif

  i2s_tx #(.SCLK_DIV(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .l_data (l_data),
    .r_data (r_data),
    .ena    (ena),
    .sclk   (sclk),
    .lrclk  (lrclk),
    .sdata  (sdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic exp_bit(input logic [23:0] w, input int k);
    logic [4:0] idx;
`ifdef I2S_LJ_FORMAT_EN
    if (k <= 23) begin
      idx = 5'(23 - k);
      return w[idx];
    end
`else
    if (k >= 1 && k <= 24) begin
      idx = 5'(24 - k);
      return w[idx];
    end
`endif
    return 1'b0;
  endfunction

  function automatic logic exp_lr(input int b);
`ifdef I2S_LJ_FORMAT_EN
    return (b < 32);
`else
    return (b >= 32);
`endif
  endfunction

  // Entered just after the fall edge that starts bit 0; checks mid-bit data
  // and the ena strobe, optionally changing the inputs after bit chg_b.
  task automatic run_frame(input string name, input logic [23:0] le, input logic [23:0] re,
                           input int nbits, input int chg_b,
                           input logic [23:0] nl, input logic [23:0] nr);
    logic [23:0] w;
    for (int b = 0; b < nbits; b++) begin
      step(1);
      if (b == 32) check_val($sformatf("%s ena_width", name), 32'(ena), 32'd0);
      step(3);
      w = (b < 32) ? le : re;
      check_val($sformatf("%s sdata b%0d", name, b), 32'(sdata), 32'(exp_bit(w, b % 32)));
      check_val($sformatf("%s lrclk b%0d", name, b), 32'(lrclk), 32'(exp_lr(b)));
      if (b == chg_b) begin
        l_data = nl;
        r_data = nr;
      end
      step(4);
      check_val($sformatf("%s ena b%0d", name, b), 32'(ena), 32'(b == 31));
    end
  endtask

  initial begin
    reset  = 1'b1;
    l_data = 24'h0;
    r_data = 24'h0;
    step(3);
    check_val("rst sclk",  32'(sclk),  32'd0);
    check_val("rst lrclk", 32'(lrclk), 32'(LR_RST));
    check_val("rst sdata", 32'(sdata), 32'd0);
    check_val("rst ena",   32'(ena),   32'd0);

    l_data = 24'hA5C3F1;
    r_data = 24'h5A3C0F;
    reset  = 1'b0;
    step(3);
    check_val("sclk edge3", 32'(sclk), 32'd0);
    step(1);
    check_val("sclk edge4", 32'(sclk), 32'd1);
    step(3);
    check_val("sclk edge7",  32'(sclk),  32'd1);
    check_val("lrclk edge7", 32'(lrclk), 32'(LR_RST));
    step(1);
    check_val("first fall sclk",  32'(sclk),  32'd0);
    check_val("first fall lrclk", 32'(lrclk), 32'(exp_lr(0)));

    run_frame("f1", 24'hA5C3F1, 24'h5A3C0F, 64, 40, 24'h800000, 24'h7FFFFF);
    run_frame("f2", 24'h800000, 24'h7FFFFF, 64, 50, 24'h111111, 24'h000001);
    run_frame("f3", 24'h111111, 24'h000001, 64, 10, 24'h222222, 24'hFEDCBA);
    run_frame("f4", 24'h222222, 24'hFEDCBA, 64, -1, 24'h0, 24'h0);
    run_frame("f5", 24'h222222, 24'hFEDCBA, 40, -1, 24'h0, 24'h0);

    reset  = 1'b1;
    l_data = 24'h0F0F0F;
    r_data = 24'hF0F0F0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check_val($sformatf("midrst sclk c%0d", i),  32'(sclk),  32'd0);
      check_val($sformatf("midrst lrclk c%0d", i), 32'(lrclk), 32'(LR_RST));
      check_val($sformatf("midrst sdata c%0d", i), 32'(sdata), 32'd0);
      check_val($sformatf("midrst ena c%0d", i),   32'(ena),   32'd0);
    end
    reset = 1'b0;
    step(7);
    check_val("restart sclk edge7",  32'(sclk),  32'd1);
    check_val("restart lrclk edge7", 32'(lrclk), 32'(LR_RST));
    step(1);
    check_val("restart fall sclk",  32'(sclk),  32'd0);
    check_val("restart fall lrclk", 32'(lrclk), 32'(exp_lr(0)));
    run_frame("f6", 24'h0F0F0F, 24'hF0F0F0, 64, -1, 24'h0, 24'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
